// File: rtl/main_ctrl_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback
// sequencing with a memory-ready stall handshake.
module main_ctrl_fsm #(
    parameter bit RESET_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    // state    | meaning
    // INIT     | idle cycle after reset release
    // FETCH    | read instruction at PC, PC+4 -> PC
    // DECODE   | read registers, ALUOut = OldPC+imm
    // MEMADR   | compute load/store address
    // MEMREAD  | load data access
    // MEMWB    | write load data to register file
    // MEMWRITE | store data access
    // EXECR    | register-register ALU op
    // EXECI    | register-immediate ALU op
    // ALUWB    | write ALUOut to register file
    // BRANCH   | compare rs1/rs2, conditional PC load
    // JAL      | PC = ALUOut, ALUOut = OldPC+4
    // JALR_ADR | compute rs1+imm
    // JALR_JMP | PC = ALUOut, ALUOut = OldPC+4
    // LUI      | ALUOut = 0+imm
    // AUIPC    | ALUOut = OldPC+imm
    typedef enum logic [3:0] {
        INIT     = 4'd0,  FETCH    = 4'd1,  DECODE   = 4'd2,  MEMADR   = 4'd3,
        MEMREAD  = 4'd4,  MEMWB    = 4'd5,  MEMWRITE = 4'd6,  EXECR    = 4'd7,
        EXECI    = 4'd8,  ALUWB    = 4'd9,  BRANCH   = 4'd10, JAL      = 4'd11,
        JALR_ADR = 4'd12, JALR_JMP = 4'd13, LUI      = 4'd14, AUIPC    = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctl_t;

    localparam state_t RST_STATE = RESET_INIT ? INIT : FETCH;

    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b10;
            end
            DECODE, AUIPC: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            MEMADR, JALR_ADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            ALUWB: c.reg_write = 1'b1;
            BRANCH: begin
                c.branch    = 1'b1;
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            JAL, JALR_JMP: begin
                c.pc_update = 1'b1;
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            LUI: begin
                c.alu_src_a = 2'b11;
                c.alu_src_b = 2'b01;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t state;
    state_t nxt;
    ctl_t   ctl;
    state_t dec_target;
    logic   op_legal;

    always_comb begin
        dec_target = FETCH;
        op_legal   = 1'b1;
        case (op)
            7'b0000011, 7'b0100011: dec_target = MEMADR;
            7'b0110011:             dec_target = EXECR;
            7'b0010011:             dec_target = EXECI;
            7'b1100011:             dec_target = BRANCH;
            7'b1101111:             dec_target = JAL;
            7'b1100111:             dec_target = JALR_ADR;
            7'b0110111:             dec_target = LUI;
            7'b0010111:             dec_target = AUIPC;
            default:                op_legal   = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            INIT:     nxt = FETCH;
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE:   nxt = dec_target;
            MEMADR:   nxt = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, JALR_JMP, LUI, AUIPC: nxt = ALUWB;
            JALR_ADR: nxt = JALR_JMP;
            default:  nxt = FETCH;
        endcase
    end

    // Outputs are registered from the next state so they are valid from the
    // first cycle of each state without decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            ctl   <= ctl_for(RST_STATE);
        end else begin
            state <= nxt;
            ctl   <= ctl_for(nxt);
        end
    end

    logic fetch_done;
    assign fetch_done = (state == FETCH) && mem_ready;

    assign mem_req       = ctl.mem_req;
    assign mem_write     = ctl.mem_write;
    assign adr_src       = ctl.adr_src;
    assign ir_write      = fetch_done;
    assign pc_update     = ctl.pc_update | fetch_done;
    assign branch        = ctl.branch;
    assign reg_write     = ctl.reg_write;
    assign result_src    = ctl.result_src;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign illegal_instr = (state == DECODE) && !op_legal;
    assign state_o       = state;

endmodule

// File: doc/main_ctrl_fsm.md
Name: main_ctrl_fsm

Overview:
- Multicycle RV32I main control state machine.
- Sequences fetch, decode, execute, memory and writeback per instruction, and drives the datapath mux selects, write enables and the `branch` qualifier.
- `branch` feeds the branch decoder, which combines it with `op`/`funct3` to form per-condition branch strobes.
- Adds a memory-ready handshake so fetch and memory states stall on slow memory.

Parameters:
- RESET_INIT, 1, when 1 the FSM spends one cycle in INIT after reset release before FETCH; when 0 reset enters FETCH directly.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  7  opcode field of instruction register
- mem_ready  input  1  memory completes current access this cycle
- mem_req  output  1  memory access requested this cycle
- mem_write  output  1  store strobe to memory
- adr_src  output  1  memory address select: 0 PC, 1 result
- ir_write  output  1  instruction register / OldPC load enable
- pc_update  output  1  unconditional PC write enable
- branch  output  1  branch-evaluate qualifier to branch decoder
- reg_write  output  1  register file write enable
- result_src  output  2  00 ALUOut, 01 read data, 10 ALU result
- alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 register, 11 zero
- alu_src_b  output  2  00 rs2 register, 01 immediate, 10 constant 4
- alu_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded
- illegal_instr  output  1  one-cycle pulse on unsupported opcode
- state_o  output  4  current state encoding, debug only

Behaviour:
- Moore outputs decoded from the state register; exceptions are `ir_write`/`pc_update` in FETCH, which are additionally gated by `mem_ready`.
- All outputs not listed for a state are 0; the 2-bit selects default to 00.
- Reset:
  - `rst_n` low forces state INIT (RESET_INIT=1) or FETCH (RESET_INIT=0) immediately.
  - INIT drives all outputs 0.
  - Reset mid-instruction abandons it; no write strobe is asserted in the cycle after reset release.
- State encodings for `state_o`: INIT 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BRANCH 10, JAL 11, JALR_ADR 12, JALR_JMP 13, LUI 14, AUIPC 15.
- INIT: -> FETCH.
- FETCH:
  - mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write and pc_update = mem_ready.
  - Stays in FETCH while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE:
  - a=01, b=01, alu_op=00, so ALUOut = OldPC+imm.
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR_ADR; 0110111 -> LUI; 0010111 -> AUIPC.
  - Any other op: illegal_instr=1 this cycle, -> FETCH; no write occurs.
- MEMADR: a=10, b=01, alu_op=00. -> MEMREAD if op=0000011, else -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Holds until mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1. -> FETCH.
- MEMWRITE:
  - mem_req=1, adr_src=1, result_src=00.
  - mem_write=1 every cycle while waiting.
  - -> FETCH on mem_ready.
- EXECR: a=10, b=00, alu_op=10. -> ALUWB.
- EXECI: a=10, b=01, alu_op=10. -> ALUWB.
- ALUWB: result_src=00, reg_write=1. -> FETCH.
- BRANCH:
  - a=10, b=00, alu_op=01, result_src=00, branch=1.
  - The PC is taken from ALUOut if the decoder condition holds.
  - -> FETCH.
- JAL:
  - result_src=00, pc_update=1, a=01, b=10, alu_op=00.
  - ALUOut becomes OldPC+4.
  - -> ALUWB.
- JALR_ADR: a=10, b=01, alu_op=00. -> JALR_JMP.
- JALR_JMP: identical outputs to JAL. -> ALUWB.
- LUI: a=11, b=01, alu_op=00. -> ALUWB.
- AUIPC: a=01, b=01, alu_op=00. -> ALUWB.
- Latency with mem_ready tied high (fetch to next fetch):
  - R/I-type, LUI, AUIPC, JAL: 4 cycles.
  - JALR: 5 cycles.
  - Branch: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Each mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- pc_update, ir_write, reg_write and mem_write are never asserted in the same cycle as illegal_instr.

Test Plan:
- Reset: hold rst_n=0 mid-MEMWRITE, release -> state_o=0 for one cycle with all outputs 0, then 1; mem_write never high after release.
- R-type: op=0110011, mem_ready=1 -> state_o sequence 1,2,7,9,1; reg_write high only in 9; alu_op=10 in 7.
- Load with stall: op=0000011, mem_ready low 2 cycles in MEMREAD -> 1,2,3,4,4,4,5,1; reg_write with result_src=01 only in 5.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> ir_write/pc_update stay 0, mem_req=1; both pulse 1 exactly in the mem_ready cycle.
- Branch and JALR:
  - op=1100011 -> branch=1, alu_op=01 for exactly one cycle, then FETCH.
  - op=1100111 -> 12,13,9 with pc_update=1 and result_src=00 in 13.
- Illegal: op=1111111 in DECODE -> illegal_instr pulses one cycle, next state_o=1, no write enables asserted.
